// File: rtl/clock_timebase_if.sv
// Display/control bundle for clock_timebase: mode and set pulses in,
// registered BCD time digits, seconds tick and colon enable out.
interface clock_timebase_if;
   logic       set_mode;
   logic       inc_hour;
   logic       inc_min;
   logic [3:0] hour_tens;
   logic [3:0] hour_ones;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       tick_1hz;
   logic       colon;

   // Controls are level (set_mode) or single-cycle pulses (inc_*), sampled
   // on the rising clock edge; there is no back-pressure in either direction.
   modport master (
      output set_mode, inc_hour, inc_min,
      input  hour_tens, hour_ones, min_tens, min_ones,
      input  sec_tens, sec_ones, tick_1hz, colon
   );

   modport slave (
      input  set_mode, inc_hour, inc_min,
      output hour_tens, hour_ones, min_tens, min_ones,
      output sec_tens, sec_ones, tick_1hz, colon
   );
endinterface

// File: rtl/clock_timebase.sv
// 24-hour BCD time-of-day counter with a 1 Hz prescaler, a time-set mode
// and a blinking colon enable.
module clock_timebase #(
   parameter int CLK_HZ = 50000000
) (
   input  logic              clk,
   input  logic              rst_n,
   clock_timebase_if.slave   bus
);

   localparam int W = $clog2(CLK_HZ);
   localparam logic [W-1:0] TERM = W'(CLK_HZ - 1);
   localparam logic [W-1:0] HALF = W'(CLK_HZ / 2);

   logic [W-1:0] cnt_q, cnt_d;
   logic [3:0]   ht_q, ho_q, mt_q, mo_q, st_q, so_q;
   logic [3:0]   ht_d, ho_d, mt_d, mo_d, st_d, so_d;
   logic         tick_q, tick_d;
   logic         colon_q, colon_d;
   logic         tick;

   function automatic logic [7:0] inc60(input logic [3:0] t, input logic [3:0] o);
      if (o != 4'd9)      return {t, o + 4'd1};
      else if (t != 4'd5) return {t + 4'd1, 4'd0};
      else                return 8'h00;
   endfunction

   function automatic logic [7:0] inc24(input logic [3:0] t, input logic [3:0] o);
      if (t == 4'd2 && o == 4'd3) return 8'h00;
      else if (o == 4'd9)         return {t + 4'd1, 4'd0};
      else                        return {t, o + 4'd1};
   endfunction

   assign tick = !bus.set_mode && (cnt_q == TERM);

   always_comb begin
      cnt_d   = cnt_q;
      ht_d    = ht_q;
      ho_d    = ho_q;
      mt_d    = mt_q;
      mo_d    = mo_q;
      st_d    = st_q;
      so_d    = so_q;
      tick_d  = 1'b0;
      colon_d = colon_q;
      if (bus.set_mode) begin
         // Set mode wins over a coincident tick; minutes never carry here.
         cnt_d   = '0;
         st_d    = 4'd0;
         so_d    = 4'd0;
         colon_d = 1'b1;
         if (bus.inc_min)  {mt_d, mo_d} = inc60(mt_q, mo_q);
         if (bus.inc_hour) {ht_d, ho_d} = inc24(ht_q, ho_q);
      end else begin
         cnt_d   = tick ? '0 : cnt_q + 1'b1;
         colon_d = (cnt_q < HALF);
         tick_d  = tick;
         if (tick) begin
            {st_d, so_d} = inc60(st_q, so_q);
            if (st_q == 4'd5 && so_q == 4'd9) begin
               {mt_d, mo_d} = inc60(mt_q, mo_q);
               if (mt_q == 4'd5 && mo_q == 4'd9) {ht_d, ho_d} = inc24(ht_q, ho_q);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         ht_q    <= 4'd0;
         ho_q    <= 4'd0;
         mt_q    <= 4'd0;
         mo_q    <= 4'd0;
         st_q    <= 4'd0;
         so_q    <= 4'd0;
         tick_q  <= 1'b0;
         colon_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         ht_q    <= ht_d;
         ho_q    <= ho_d;
         mt_q    <= mt_d;
         mo_q    <= mo_d;
         st_q    <= st_d;
         so_q    <= so_d;
         tick_q  <= tick_d;
         colon_q <= colon_d;
      end
   end

   assign bus.hour_tens = ht_q;
   assign bus.hour_ones = ho_q;
   assign bus.min_tens  = mt_q;
   assign bus.min_ones  = mo_q;
   assign bus.sec_tens  = st_q;
   assign bus.sec_ones  = so_q;
   assign bus.tick_1hz  = tick_q;
   assign bus.colon     = colon_q;

endmodule

// File: tb/tb_clock_timebase.sv
// Bench for clock_timebase at CLK_HZ=4: directed scenarios plus random
// mode/pulse traffic, checked every cycle against a seconds-of-day model.
module tb_clock_timebase;
   localparam int CLK_HZ = 4;

   logic clk;
   logic rst_n;
   clock_timebase_if bus();

   clock_timebase #(.CLK_HZ(CLK_HZ)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;
   logic [25:0] exp_q[$];

   // model: time as seconds of day, phase as cycles into the current second
   int m_secs  = 0;
   int m_phase = 0;
   bit m_tick  = 0;
   bit m_colon = 0;

   function automatic logic [25:0] model_vec();
      int h, m, s;
      h = m_secs / 3600;
      m = (m_secs / 60) % 60;
      s = m_secs % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
              4'(s / 10), 4'(s % 10), m_tick, m_colon};
   endfunction

   function automatic logic [23:0] dut_time();
      return {bus.hour_tens, bus.hour_ones, bus.min_tens, bus.min_ones,
              bus.sec_tens, bus.sec_ones};
   endfunction

   function automatic logic [25:0] dut_vec();
      return {dut_time(), bus.tick_1hz, bus.colon};
   endfunction

   task automatic model_reset();
      m_secs = 0; m_phase = 0; m_tick = 0; m_colon = 0;
   endtask

   task automatic model_edge(input bit sm, input bit ih, input bit im);
      int h, m;
      if (sm) begin
         h = m_secs / 3600;
         m = (m_secs / 60) % 60;
         if (im) m = (m + 1) % 60;
         if (ih) h = (h + 1) % 24;
         m_secs  = h * 3600 + m * 60;
         m_phase = 0;
         m_tick  = 0;
         m_colon = 1;
      end else begin
         m_tick  = (m_phase == CLK_HZ - 1);
         m_colon = (m_phase < CLK_HZ / 2);
         if (m_tick) m_secs = (m_secs + 1) % 86400;
         m_phase = (m_phase + 1) % CLK_HZ;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // driver: called at a falling edge, returns at the next falling edge
   task automatic cycle(input bit sm, input bit ih, input bit im);
      bus.set_mode = sm;
      bus.inc_hour = ih;
      bus.inc_min  = im;
      @(posedge clk);
      model_edge(sm, ih, im);
      exp_q.push_back(model_vec());
      #1;
      check("cycle", 32'(dut_vec()), 32'(exp_q.pop_front()));
      @(negedge clk);
   endtask

   task automatic run_ticks(input int n);
      repeat (n * CLK_HZ) cycle(0, 0, 0);
   endtask

   task automatic set_time(input int h, input int m);
      int dh, dm;
      cycle(1, 0, 0);
      dh = (h - m_secs / 3600 + 24) % 24;
      dm = (m - (m_secs / 60) % 60 + 60) % 60;
      repeat (dh) cycle(1, 1, 0);
      repeat (dm) cycle(1, 0, 1);
   endtask

   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check(tag, 32'(dut_vec()), 32'h0);
      check({tag, "_model"}, 32'(dut_vec()), 32'(model_vec()));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bit mode;
      rst_n = 1'b0;
      bus.set_mode = 1'b0;
      bus.inc_hour = 1'b0;
      bus.inc_min  = 1'b0;
      #1;
      check("reset_state", 32'(dut_vec()), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // first second after reset: colon on cycles 1-2, tick on cycle 4
      cycle(0, 0, 0); check("colon_c1", 32'(bus.colon), 32'd1);
      cycle(0, 0, 0); check("colon_c2", 32'(bus.colon), 32'd1);
      cycle(0, 0, 0); check("colon_c3", 32'(bus.colon), 32'd0);
      cycle(0, 0, 0); check("first_tick", 32'({bus.tick_1hz, dut_time()}), 32'h1000001);

      // 23:59:59 rollover
      set_time(23, 59);
      run_ticks(59);
      check("t235959", 32'(dut_time()), 32'h235959);
      run_ticks(1);
      check("rollover", 32'({bus.tick_1hz, dut_time()}), 32'h1000000);

      // hour 09->10 and 19->20 BCD carries
      set_time(9, 59);
      run_ticks(59);
      check("t095959", 32'(dut_time()), 32'h095959);
      run_ticks(1);
      check("t100000", 32'(dut_time()), 32'h100000);
      set_time(19, 59);
      run_ticks(60);
      check("t200000", 32'(dut_time()), 32'h200000);

      // inc pulses ignored in run mode, then entering set mode clears seconds
      set_time(12, 34);
      run_ticks(20);
      repeat (CLK_HZ) cycle(0, 1, 1);
      run_ticks(6);
      check("run_inc_ignored", 32'(dut_time()), 32'h123427);
      cycle(1, 0, 0);
      check("set_entry", 32'({bus.tick_1hz, bus.colon, dut_time()}), 32'h1123400);
      repeat (8) cycle(1, 0, 0);

      // simultaneous inc_hour/inc_min at 23:59
      set_time(23, 59);
      cycle(1, 1, 1);
      check("both_inc", 32'(dut_time()), 32'h000000);

      // set_mode rising on the tick cycle
      set_time(8, 15);
      repeat (CLK_HZ - 1) cycle(0, 0, 0);
      cycle(1, 0, 0);
      check("set_on_tick", 32'({bus.tick_1hz, dut_time()}), 32'h0081500);

      // async reset at 05:06:07 and mid-set
      set_time(5, 6);
      run_ticks(7);
      check("t050607", 32'(dut_time()), 32'h050607);
      async_reset("reset_mid_run");
      repeat (CLK_HZ - 1) cycle(0, 0, 0);
      check("post_reset_no_tick", 32'(bus.tick_1hz), 32'd0);
      cycle(0, 0, 0);
      check("post_reset_tick", 32'({bus.tick_1hz, dut_time()}), 32'h1000001);
      set_time(3, 3);
      async_reset("reset_mid_set");
      run_ticks(1);
      check("post_set_reset", 32'({bus.tick_1hz, dut_time()}), 32'h1000001);

      // random mode changes, pulses and occasional resets
      mode = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 63) == 0) mode = ~mode;
         if ($urandom_range(0, 499) == 0) async_reset("reset_random");
         else cycle(mode, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/clock_timebase.md
CLOCK_TIMEBASE -- requirements
Module: clock_timebase

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz; the block SHALL support any value >= 4.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 set_mode  input  1  high = time-set mode, low = run mode.
REQ-005 inc_hour  input  1  single-cycle pulse, already debounced; increments hours in set mode.
REQ-006 inc_min  input  1  single-cycle pulse, already debounced; increments minutes in set mode.
REQ-007 hour_tens  output  4  BCD, range 0-2.
REQ-008 hour_ones  output  4  BCD, range 0-9, and 0-3 when hour_tens=2.
REQ-009 min_tens  output  4  BCD 0-5.
REQ-010 min_ones  output  4  BCD 0-9.
REQ-011 sec_tens  output  4  BCD 0-5.
REQ-012 sec_ones  output  4  BCD 0-9.
REQ-013 tick_1hz  output  1  one-cycle pulse marking each seconds update.
REQ-014 colon  output  1  colon-segment enable for the display.

Function
REQ-015 Prescaler: counter width ceil(log2(CLK_HZ)), counts 0..CLK_HZ-1 and wraps to 0; the terminal count SHALL be the internal tick.
REQ-016 Run mode, tick cycle: seconds SHALL increment by 1, with the new value visible at the outputs in the same cycle as tick_1hz=1.
REQ-017 Carry rules: sec 59->00 SHALL carry +1 minute; min 59->00 SHALL carry +1 hour; hour 23->00; 23:59:59->00:00:00 SHALL occur in a single cycle.
REQ-018 BCD carries: ones 9->0 SHALL carry +1 into tens within the same field, and hour 09->10 and 19->20 SHALL be correct.
REQ-019 All digit outputs SHALL be registered; no invalid BCD code or out-of-range field value SHALL ever appear.
REQ-020 Set mode: the prescaler SHALL be held at 0, seconds SHALL be forced to 00, tick_1hz SHALL be 0, and colon SHALL be 1.
REQ-021 Set mode, inc_min: minutes SHALL increment and wrap 59->00 with no carry into hours, taking effect on the next cycle.
REQ-022 Set mode, inc_hour: hours SHALL increment and wrap 23->00, taking effect on the next cycle.
REQ-023 When inc_hour and inc_min are asserted in the same cycle, both SHALL apply independently.
REQ-024 In run mode, inc_hour and inc_min SHALL be ignored.
REQ-025 On a set_mode falling edge, the prescaler SHALL restart from 0, so the first tick occurs exactly CLK_HZ cycles after the first run-mode cycle.
REQ-026 Run mode, colon: the registered colon SHALL be 1 while the prescaler value is < CLK_HZ/2 (integer division) and 0 otherwise, giving a 1 Hz blink.
REQ-027 A set_mode rising edge coinciding with a tick: set mode SHALL take priority, so seconds are forced to 00 and tick_1hz=0.

Reset
REQ-028 rst_n low SHALL, without waiting for clk, set the prescaler to 0, all six digits to 0 (00:00:00), tick_1hz to 0 and colon to 0.
REQ-029 Reset asserted mid-second or mid-set SHALL discard all partial state; after release the first tick occurs CLK_HZ cycles after the first clock edge with rst_n high.
REQ-030 rst_n deassertion is synchronised externally; the block SHALL NOT add reset synchronisers.

Verification (CLK_HZ=4)
REQ-031 Release reset with set_mode=0 -> outputs 00:00:00, colon high on cycles 1-2 of each second, first tick_1hz on cycle 4 with sec_ones=1.
REQ-032 Set mode with 23 inc_hour and 59 inc_min pulses, then run 59 ticks -> 23:59:59; next tick -> 00:00:00 in one cycle with tick_1hz=1.
REQ-033 Preload 09:59, run 59 ticks, then one more -> 10:00:00; repeat from 19:59:59 -> 20:00:00.
REQ-034 Run mode, pulse inc_hour and inc_min -> time unchanged; enter set mode at 12:34:27 -> 12:34:00, colon=1, no ticks.
REQ-035 Set mode at 23:59, inc_hour and inc_min asserted in the same cycle -> 00:00, hours not double-incremented.
REQ-036 Assert rst_n low between clock edges at 05:06:07 -> all outputs 0 before the next rising edge.
